// File: rtl/sap_sequencer.sv
// Fetch/execute/writeback controller for the 8-bit SAP datapath.
// Accepts instruction words over valid/ready, drives registered datapath controls, captures ALU results.

package sap_sequencer_pkg;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_PASS = 3'd5
  } alu_op_e;
endpackage

module sap_sequencer
  import sap_sequencer_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [N-1:0]     alu_y,
  input  logic             z,
  input  logic             n,
  input  logic             c,
  input  logic             v,
  output alu_op_e          op,
  output logic             en_A,
  output logic             en_B,
  output logic             sel_A,
  output logic             sel_B,
  output logic             load_out,
  output logic [N-1:0]     imm_data,
  output logic [N-1:0]     bus_in,
  output logic [N-1:0]     result,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2,
    S_HALT = 2'd3
  } state_e;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_LDA  = 4'h1;
  localparam logic [3:0] OPC_LDB  = 4'h2;
  localparam logic [3:0] OPC_HALT = 4'hF;

  state_e           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic             err_q, err_d;
  logic [N-1:0]     result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  alu_op_e          op_q, op_d;
  logic             enA_q, enA_d;
  logic             enB_q, enB_d;
  logic             selA_q, selA_d;
  logic             selB_q, selB_d;
  logic             loadOut_q, loadOut_d;
  logic [N-1:0]     imm_q, imm_d;
  logic             wbBus_q, wbBus_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;

  logic             handshake;
  logic [3:0]       opcCur;
  logic [3:0]       opcNext;

  function automatic logic isAluOp(input logic [3:0] opc);
    return (opc >= 4'h3) && (opc <= 4'h8);
  endfunction

  function automatic logic isUndefOp(input logic [3:0] opc);
    return (opc >= 4'h9) && (opc <= 4'hE);
  endfunction

  function automatic alu_op_e aluMap(input logic [3:0] opc);
    case (opc)
      4'h3:    return ALU_ADD;
      4'h4:    return ALU_SUB;
      4'h5:    return ALU_AND;
      4'h6:    return ALU_OR;
      4'h7:    return ALU_XOR;
      default: return ALU_PASS;
    endcase
  endfunction

  assign handshake = instr_valid && ready_q;
  assign opcCur    = ir_q[15:12];

  // Instruction sequencing, result capture and retirement counting.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    err_d     = err_q;
    result_d  = result_q;
    flags_d   = flags_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          ir_d    = instr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (isAluOp(opcCur)) begin
          state_d = S_WB;
        end else begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = (opcCur == OPC_HALT) ? S_HALT : S_IDLE;
          if (isUndefOp(opcCur)) err_d = 1'b1;
        end
      end
      S_WB: begin
        result_d  = alu_y;
        flags_d   = {z, n, c, v};
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Controls are decoded from the upcoming state and IR so they are registered, never from instr_valid.
  always_comb begin
    opcNext   = ir_d[15:12];
    op_d      = ALU_PASS;
    enA_d     = 1'b0;
    enB_d     = 1'b0;
    selA_d    = 1'b0;
    selB_d    = 1'b0;
    loadOut_d = 1'b0;
    imm_d     = N'(ir_d[7:0]);
    wbBus_d   = 1'b0;
    case (state_d)
      S_EXEC: begin
        if (opcNext == OPC_LDA) enA_d = 1'b1;
        if (opcNext == OPC_LDB) enB_d = 1'b1;
        if (isAluOp(opcNext))   op_d  = aluMap(opcNext);
      end
      S_WB: begin
        op_d      = aluMap(opcNext);
        loadOut_d = 1'b1;
        if (ir_d[11]) begin
          selA_d  = 1'b1;
          enA_d   = 1'b1;
          wbBus_d = 1'b1;
        end
      end
      default: ;
    endcase
    ready_d  = (state_d == S_IDLE);
    busy_d   = (state_d == S_EXEC) || (state_d == S_WB);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      err_q     <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      retired_q <= '0;
      op_q      <= ALU_PASS;
      enA_q     <= 1'b0;
      enB_q     <= 1'b0;
      selA_q    <= 1'b0;
      selB_q    <= 1'b0;
      loadOut_q <= 1'b0;
      imm_q     <= '0;
      wbBus_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      err_q     <= err_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      retired_q <= retired_d;
      op_q      <= op_d;
      enA_q     <= enA_d;
      enB_q     <= enB_d;
      selA_q    <= selA_d;
      selB_q    <= selB_d;
      loadOut_q <= loadOut_d;
      imm_q     <= imm_d;
      wbBus_q   <= wbBus_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

  // The writeback bus forwards the live ALU output; it is stable during WB since A and B are not loading.
  assign bus_in      = wbBus_q ? alu_y : '0;
  assign op          = op_q;
  assign en_A        = enA_q;
  assign en_B        = enB_q;
  assign sel_A       = selA_q;
  assign sel_B       = selB_q;
  assign load_out    = loadOut_q;
  assign imm_data    = imm_q;
  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign err         = err_q;
  assign result      = result_q;
  assign flags       = flags_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_sap_sequencer.sv
// Directed testbench for sap_sequencer with a small behavioral SAP datapath attached.
// Expected values are hand-computed constants.

module tb_sap_sequencer;
  import sap_sequencer_pkg::*;

  localparam int N     = 8;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic [15:0]      instr;
  logic             instr_valid;
  logic             instr_ready;
  logic [N-1:0]     alu_y;
  logic             z, n, c, v;
  alu_op_e          op;
  logic             en_A, en_B, sel_A, sel_B, load_out;
  logic [N-1:0]     imm_data, bus_in, result;
  logic [3:0]       flags;
  logic             busy, halted, err;
  logic [CNT_W-1:0] retired;

  int passCount;
  int checkCount;

  sap_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_y(alu_y), .z(z), .n(n), .c(c), .v(v),
    .op(op), .en_A(en_A), .en_B(en_B), .sel_A(sel_A), .sel_B(sel_B),
    .load_out(load_out), .imm_data(imm_data), .bus_in(bus_in),
    .result(result), .flags(flags), .busy(busy), .halted(halted),
    .err(err), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioral datapath: A/B registers, output register and an 8-bit ALU.
  logic [N-1:0] regA, regB, outReg;
  logic [N:0]   wide;

  always_comb begin
    wide = '0;
    v    = 1'b0;
    case (op)
      ALU_ADD: begin
        wide = {1'b0, regA} + {1'b0, regB};
        v    = (regA[7] == regB[7]) && (wide[7] != regA[7]);
      end
      ALU_SUB: begin
        wide = {1'b0, regA} - {1'b0, regB};
        v    = (regA[7] != regB[7]) && (wide[7] != regA[7]);
      end
      ALU_AND: wide = {1'b0, regA & regB};
      ALU_OR:  wide = {1'b0, regA | regB};
      ALU_XOR: wide = {1'b0, regA ^ regB};
      default: wide = {1'b0, regA};
    endcase
    alu_y = wide[7:0];
    c     = wide[8];
    z     = (wide[7:0] == 8'h00);
    n     = wide[7];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regA   <= '0;
      regB   <= '0;
      outReg <= '0;
    end else begin
      if (en_A)     regA   <= sel_A ? bus_in : imm_data;
      if (en_B)     regB   <= sel_B ? bus_in : imm_data;
      if (load_out) outReg <= alu_y;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp)
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    else
      passCount++;
  endtask

  task automatic doReset();
    reset       = 1'b1;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Presents a word and returns just after the edge on which it was accepted.
  task automatic sendWord(input logic [15:0] w);
    bit got;
    got = 0;
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (instr_ready) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      checkOutput("readyTimeout", 32'(instr_ready), 32'd1);
      instr_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
    end
  endtask

  task automatic waitIdle();
    bit done;
    done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
    end
    if (!done) checkOutput("idleTimeout", 32'(busy), 32'd0);
  endtask

  task automatic applyStimulus(input logic [15:0] w);
    sendWord(w);
    waitIdle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int hsCycle[4];
    int hsCount;
    int cyc;
    logic [15:0] queued[4];

    passCount   = 0;
    checkCount  = 0;
    instr       = 16'h0000;
    instr_valid = 1'b0;
    reset       = 1'b1;
    doReset();

    // Reset values
    checkOutput("rstReady",   32'(instr_ready), 32'd1);
    checkOutput("rstBusy",    32'(busy),        32'd0);
    checkOutput("rstHalted",  32'(halted),      32'd0);
    checkOutput("rstErr",     32'(err),         32'd0);
    checkOutput("rstResult",  32'(result),      32'd0);
    checkOutput("rstFlags",   32'(flags),       32'd0);
    checkOutput("rstRetired", 32'(retired),     32'd0);
    checkOutput("rstOp",      32'(op),          32'(ALU_PASS));
    checkOutput("rstCtl",     32'({en_A, en_B, sel_A, sel_B, load_out}), 32'd0);
    checkOutput("rstImm",     32'(imm_data),    32'd0);
    checkOutput("rstBus",     32'(bus_in),      32'd0);

    // LDA 0x0A, LDB 0x05, ADD wb=0, stepping the ADD cycle by cycle
    sendWord(16'h100A);
    checkOutput("ldaEnA",  32'(en_A),     32'd1);
    checkOutput("ldaImm",  32'(imm_data), 32'h0A);
    waitIdle();
    applyStimulus(16'h2005);
    checkOutput("ldbB",    32'(regB),     32'h05);
    sendWord(16'h3000);
    checkOutput("addExecOp",   32'(op),       32'(ALU_ADD));
    checkOutput("addExecLoad", 32'(load_out), 32'd0);
    @(posedge clk); #1;
    checkOutput("addWbLoad",   32'(load_out), 32'd1);
    checkOutput("addWbEnA",    32'(en_A),     32'd0);
    checkOutput("addWbOp",     32'(op),       32'(ALU_ADD));
    @(posedge clk); #1;
    checkOutput("addIdleLoad", 32'(load_out), 32'd0);
    checkOutput("addResult",   32'(result),   32'h0F);
    checkOutput("addFlags",    32'(flags),    32'h0);
    checkOutput("addRetired",  32'(retired),  32'd3);
    checkOutput("addAKept",    32'(regA),     32'h0A);
    checkOutput("addOutReg",   32'(outReg),   32'h0F);

    // LDA 0x0A, LDB 0x05, SUB wb=1, PASS
    applyStimulus(16'h100A);
    applyStimulus(16'h2005);
    applyStimulus(16'h4800);
    checkOutput("subA",       32'(regA),    32'h05);
    checkOutput("subResult",  32'(result),  32'h05);
    applyStimulus(16'h8000);
    checkOutput("passResult", 32'(result),  32'h05);
    checkOutput("passRetired", 32'(retired), 32'd7);

    // AND giving zero, XOR giving negative
    applyStimulus(16'h10F0);
    applyStimulus(16'h200F);
    applyStimulus(16'h5000);
    checkOutput("andResult", 32'(result), 32'h00);
    checkOutput("andFlags",  32'(flags),  32'h8);
    applyStimulus(16'h10AA);
    applyStimulus(16'h2055);
    applyStimulus(16'h7000);
    checkOutput("xorResult", 32'(result), 32'hFF);
    checkOutput("xorFlags",  32'(flags),  32'h4);
    checkOutput("xorRetired", 32'(retired), 32'd13);

    // Four words queued with instr_valid held high
    queued[0] = 16'h1003;
    queued[1] = 16'h2004;
    queued[2] = 16'h3800;
    queued[3] = 16'h2001;
    hsCount   = 0;
    cyc       = 0;
    @(negedge clk);
    instr       = queued[0];
    instr_valid = 1'b1;
    for (int i = 0; i < 40 && hsCount < 4; i++) begin
      if (i > 0) @(negedge clk);
      cyc++;
      if (instr_ready) begin
        hsCycle[hsCount] = cyc;
        hsCount++;
        @(posedge clk);
        #1;
        if (hsCount < 4) instr = queued[hsCount];
        else             instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    checkOutput("queueCount", 32'(hsCount), 32'd4);
    if (hsCount == 4) begin
      checkOutput("gapLda", 32'(hsCycle[1] - hsCycle[0]), 32'd2);
      checkOutput("gapLdb", 32'(hsCycle[2] - hsCycle[1]), 32'd2);
      checkOutput("gapAdd", 32'(hsCycle[3] - hsCycle[2]), 32'd3);
    end
    waitIdle();
    checkOutput("queueA",       32'(regA),    32'h07);
    checkOutput("queueB",       32'(regB),    32'h01);
    checkOutput("queueResult",  32'(result),  32'h07);
    checkOutput("queueRetired", 32'(retired), 32'd17);

    // Undefined opcode, HALT, then a load that must not be taken
    doReset();
    applyStimulus(16'hB000);
    checkOutput("undefErr", 32'(err), 32'd1);
    applyStimulus(16'hF000);
    hsCount = 0;
    instr       = 16'h1011;
    instr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (instr_ready) hsCount++;
    end
    instr_valid = 1'b0;
    checkOutput("haltNoHs",    32'(hsCount),     32'd0);
    checkOutput("haltErr",     32'(err),         32'd1);
    checkOutput("haltHalted",  32'(halted),      32'd1);
    checkOutput("haltReady",   32'(instr_ready), 32'd0);
    checkOutput("haltBusy",    32'(busy),        32'd0);
    checkOutput("haltA",       32'(regA),        32'h00);
    checkOutput("haltRetired", 32'(retired),     32'd2);

    // Reset asserted during the WB cycle of an ADD wb=1
    doReset();
    applyStimulus(16'h1001);
    applyStimulus(16'h2002);
    applyStimulus(16'h3000);
    checkOutput("preRstResult", 32'(result), 32'h03);
    sendWord(16'h3800);
    @(posedge clk); #1;
    checkOutput("wbLoadBefore", 32'(load_out), 32'd1);
    checkOutput("wbEnABefore",  32'(en_A),     32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rstWbLoad",    32'(load_out),    32'd0);
    checkOutput("rstWbEnA",     32'(en_A),        32'd0);
    checkOutput("rstWbRetired", 32'(retired),     32'd0);
    checkOutput("rstWbResult",  32'(result),      32'd0);
    checkOutput("rstWbReady",   32'(instr_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(16'h1033);
    checkOutput("afterRstA",       32'(regA),    32'h33);
    checkOutput("afterRstRetired", 32'(retired), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sap_sequencer.md
# sap_sequencer

Instruction-level controller for the 8-bit SAP datapath. It accepts 16-bit instruction words over a valid/ready handshake, decodes them, and sequences the datapath controls (`op`, `en_A`, `en_B`, `sel_A`, `sel_B`, `load_out`, `imm_data`, `bus_in`) through a fetch/execute/writeback state machine. It also latches the datapath's ALU result and Z/N/C/V flags, and counts retired instructions. It sits between an instruction source (test ROM or host FIFO) and the `datapath` instance.

## Interface
- `N`, 8: datapath width; must match the `datapath` instance.
- `CNT_W`, 16: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `instr`  in  16  instruction word: [15:12] opcode, [11] wb, [10:8] reserved (ignored), [7:0] imm.
- `instr_valid`  in  1  instruction source has a word on `instr`.
- `instr_ready`  out  1  sequencer can accept a word this cycle.
- `alu_y`  in  N  datapath ALU output.
- `z`, `n`, `c`, `v`  in  1 each  datapath ALU flags.
- `op`  out  alu_op_e  ALU operation select to datapath.
- `en_A`, `en_B`  out  1  register load enables.
- `sel_A`, `sel_B`  out  1  source select: 1 = `bus_in`, 0 = `imm_data`.
- `load_out`  out  1  output-register load strobe.
- `imm_data`  out  N  immediate to datapath.
- `bus_in`  out  N  bus value to datapath (ALU writeback path).
- `result`  out  N  last ALU result captured at writeback.
- `flags`  out  4  {z,n,c,v} captured at writeback.
- `busy`  out  1  state is not IDLE or HALT.
- `halted`  out  1  HALT state reached.
- `err`  out  1  sticky; set by an undefined opcode.
- `retired`  out  CNT_W  count of completed instructions; wraps.

## Operation
- Opcodes:
  - 0x0 NOP.
  - 0x1 LDA imm.
  - 0x2 LDB imm.
  - 0x3 ADD, 0x4 SUB, 0x5 AND, 0x6 OR, 0x7 XOR: map to ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR.
  - 0x8 PASS: maps to ALU_PASS.
  - 0xF HALT.
  - 0x9–0xE undefined.
- Instruction register (IR) captures `instr` on the handshake edge (`instr_valid && instr_ready`).
- States:
  - **IDLE**: `instr_ready`=1. On handshake, load IR and go to EXEC.
  - **EXEC**:
    - LDA: `imm_data`=IR.imm, `sel_A`=0, `en_A`=1; go to IDLE.
    - LDB: same using `sel_B`/`en_B`; go to IDLE.
    - ALU ops: drive `op`, no enables (settle cycle); go to WB.
    - NOP: go to IDLE.
    - Undefined: set `err`, behave as NOP.
    - HALT: go to HALT.
  - **WB**: `op` held; `load_out`=1; `result`←`alu_y`, `flags`←{z,n,c,v} at the edge.
    - If IR.wb=1, also `sel_A`=1, `en_A`=1, `bus_in`=`alu_y`, so A←result.
    - Go to IDLE.
  - **HALT**: `instr_ready`=0; all enables 0; remains here until reset.
- `retired` increments on leaving EXEC for NOP, LDA, LDB, undefined opcodes and HALT, and on leaving WB. It wraps from all-ones to 0.
- Datapath controls are decoded from state and IR only. They never depend on `instr_valid` in the same cycle.
- Outside the cycles listed above:
  - `op`=ALU_PASS; all enables and `load_out`=0.
  - `imm_data`=IR.imm; `bus_in`=0; `sel_A`=`sel_B`=0.

## Timing
- Reset values:
  - State IDLE, IR=0.
  - `instr_ready`=1; `busy`, `halted`, `err`=0.
  - `result`=0, `flags`=0, `retired`=0.
  - All enables and `load_out`=0; `op`=ALU_PASS; `imm_data`=`bus_in`=0.
- Reset is asynchronous. Asserting it mid-EXEC or mid-WB drops the enables in the same cycle, and any in-flight instruction is discarded, uncounted.
- LDA/LDB: handshake at edge T; enable high during cycle T+1; register updated at edge T+2. Two cycles per instruction.
- ALU op: handshake at edge T; EXEC during T+1; WB during T+2; `out_reg`, `result`, `flags` and (if wb) A updated at edge T+3. Three cycles per instruction.
- Back-to-back: `instr_ready` is high only in IDLE. With `instr_valid` held high, the next handshake occurs at the first edge after returning to IDLE.
- Held `instr_valid` with `instr_ready`=0 is not consumed. `instr` may change freely while unaccepted.

## Test plan
- Reset, then LDA 0x0A, LDB 0x05, ADD wb=0 -> `load_out` pulses in the WB cycle only; `result`=0x0F; flags z=0; `retired`=3; A still 0x0A.
- LDA 0x0A, LDB 0x05, SUB wb=1, then PASS -> after SUB, A=0x05 and `result`=0x05; after PASS, `result`=0x05.
- LDA 0xF0, LDB 0x0F, AND -> `result`=0x00, z=1. Then XOR with A=0xAA, B=0x55 -> `result`=0xFF, n=1.
- `instr_valid` held high with 4 queued words -> handshakes spaced 2 cycles for loads and 3 cycles for ALU ops; no word lost or duplicated.
- Opcode 0xB, then HALT, then LDA 0x11 presented -> `err`=1, `halted`=1, `instr_ready` stays 0, A unchanged, `retired`=2.
- Assert `reset` during the WB cycle of an ADD -> `load_out` and `en_A` drop immediately; `retired` and `result` return to 0; after release the sequencer accepts the next instruction in IDLE.
